// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client (icache/dcache) line arbiter in front of a single memory port
module mem_arbiter #(
  parameter int DCACHE_PRIORITY = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_icache_req,
  input  logic [31:0]  in_icache_addr,
  output logic [127:0] out_icache_data,
  output logic         out_icache_ready,
  input  logic         in_dcache_req,
  input  logic         in_dcache_we,
  input  logic [31:0]  in_dcache_addr,
  input  logic [127:0] in_dcache_write_data,
  output logic [127:0] out_dcache_data,
  output logic         out_dcache_ready,
  output logic         out_mem_read_en,
  output logic         out_mem_write_en,
  output logic [31:0]  out_mem_addr,
  output logic [127:0] out_mem_write_data,
  input  logic [127:0] in_mem_read_data,
  input  logic         in_mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic owner_d, op_we, last_d, grant_d, any_req;
  assign any_req = in_icache_req || in_dcache_req;
  // dcache wins when alone, when priority is fixed, or when icache was served last
  assign grant_d = in_dcache_req && (!in_icache_req || DCACHE_PRIORITY != 0 || !last_d);
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next state and outputs; enables drop in the in_mem_ready cycle so memory does not restart
  always_comb begin
    state_nx = state == IDLE ? (any_req ? BUSY : IDLE) :
               state == BUSY ? (in_mem_ready ? DONE : BUSY) : IDLE;
    out_mem_read_en  = state == BUSY && !op_we && !in_mem_ready;
    out_mem_write_en = state == BUSY && op_we && !in_mem_ready;
    out_icache_ready = state == DONE && !owner_d;
    out_dcache_ready = state == DONE && owner_d;
  end
  // grant latching, returned-line capture and round-robin history
  always_ff @(posedge clk)
    if (reset) begin
      owner_d            <= 1'b0;
      op_we              <= 1'b0;
      last_d             <= 1'b0;
      out_mem_addr       <= '0;
      out_mem_write_data <= '0;
      out_icache_data    <= '0;
      out_dcache_data    <= '0;
    end else if (state == IDLE && any_req) begin
      owner_d            <= grant_d;
      op_we              <= grant_d && in_dcache_we;
      out_mem_addr       <= {grant_d ? in_dcache_addr[31:4] : in_icache_addr[31:4], 4'b0};
      out_mem_write_data <= in_dcache_write_data;
    end else if (state == BUSY && in_mem_ready) begin
      last_d <= owner_d;
      if (!op_we && owner_d) out_dcache_data <= in_mem_read_data;
      if (!op_we && !owner_d) out_icache_data <= in_mem_read_data;
    end
endmodule
